// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small
// byte FIFO with valid/ready output and sticky frame-error / overflow flags.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overflow_o,
    input  logic       clr_i
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   DepthVal = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    logic            push, frame_set;
    logic            fall;

    assign fall = prev_q & ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        state_d   = StData;
                        cnt_d     = FullLoad;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FullLoad;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == '0) begin
                    par_err_d = (^shift_q) ^ sync2_q;
                    cnt_d     = FullLoad;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                    if (sync2_q && !par_err_q) begin
`else
                    if (sync2_q) begin
`endif
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Disable only parks the receiver; FIFO and flags keep their state.
        if (!ena) begin
            state_d   = StIdle;
            cnt_d     = '0;
            bit_idx_d = '0;
            push      = 1'b0;
            frame_set = 1'b0;
        end
    end

    assign busy_o = (state_q != StIdle);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            frame_err_q, overflow_q;
    logic            pop, full, push_ok, ovf_set;

    assign pop     = (count_q != '0) & ready_i;
    assign full    = (count_q == DepthVal);
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            // Set has priority over a coincident clear.
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (clr_i) begin
                frame_err_q <= 1'b0;
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign valid_o     = (count_q != '0);
    assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule
